// File: rtl/dijkstra_pkg.sv
// dijkstra_pkg: shared types and helpers for the Dijkstra accelerator slice.
// Holds the edge-cache loader state enum, default widths and address packing.
package dijkstra_pkg;

   localparam int NODE_BITS_DEF  = 7;
   localparam int ADDR_WIDTH_DEF = 16;
   localparam int DATA_WIDTH_DEF = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WRITE,
      ST_VERIFY,
      ST_DONE
   } loader_state_t;

   // Slave decodes {to, from}; upper address bits are zero.
   function automatic logic [31:0] pack_edge_addr(
      input logic [31:0] i_from,
      input logic [31:0] i_to,
      input int          i_nb
   );
      logic [31:0] v_mask;
      v_mask = (32'd1 << i_nb) - 32'd1;
      return ((i_to & v_mask) << i_nb) | (i_from & v_mask);
   endfunction

endpackage

// File: rtl/edge_cache_loader_if.sv
// edge_cache_loader_if: edge stream input plus Avalon-MM master bus.
// master = loader side, slave = stream source / accelerator side.
interface edge_cache_loader_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
) ();

   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] m_address;
   logic                  m_write;
   logic [DATA_WIDTH-1:0] m_writedata;
   logic                  m_read;
   logic [DATA_WIDTH-1:0] m_readdata;
   logic                  m_waitrequest;

   modport master (
      input  in_valid,
      input  in_data,
      output in_ready,
      output m_address,
      output m_write,
      output m_writedata,
      output m_read,
      input  m_readdata,
      input  m_waitrequest
   );

   modport slave (
      output in_valid,
      output in_data,
      input  in_ready,
      input  m_address,
      input  m_write,
      input  m_writedata,
      input  m_read,
      output m_readdata,
      output m_waitrequest
   );

endinterface

// File: rtl/edge_index_counter.sv
// edge_index_counter: row-major (from outer, to inner) node-pair walker.
// o_last flags the final edge (N-1, N-1) of the current load.
module edge_index_counter #(
   parameter int NODE_BITS = 7
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_clear,
   input  logic             i_advance,
   input  logic [NODE_BITS:0] i_num_nodes,
   output logic [NODE_BITS:0] o_from,
   output logic [NODE_BITS:0] o_to,
   output logic             o_last
);

   logic [NODE_BITS:0] r_from;
   logic [NODE_BITS:0] r_to;
   logic [NODE_BITS:0] w_max;

   assign w_max  = i_num_nodes - 1'b1;
   assign o_last = (r_from == w_max) && (r_to == w_max);
   assign o_from = r_from;
   assign o_to   = r_to;

   // Step to-index each completed edge, wrapping into the next row.
   always_ff @(posedge clock) begin
      if (reset || i_clear) begin
         r_from <= '0;
         r_to   <= '0;
      end else if (i_advance) begin
         if (r_to == w_max) begin
            r_to   <= '0;
            r_from <= r_from + 1'b1;
         end else begin
            r_to <= r_to + 1'b1;
         end
      end
   end

endmodule

// File: rtl/edge_cache_loader.sv
// edge_cache_loader: streams an N x N weight matrix into the edge cache.
// Define EDGE_CACHE_LOADER_VERIFY_EN to read back and count mismatches.
module edge_cache_loader
   import dijkstra_pkg::*;
#(
   parameter int NODE_BITS  = NODE_BITS_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   cmd_start,
   input  logic [NODE_BITS:0]     cmd_num_nodes,
   output logic                   busy,
   output logic                   done,
   output logic                   cmd_error,
   output logic [2*NODE_BITS:0]   edges_written,
`ifdef EDGE_CACHE_LOADER_VERIFY_EN
   output logic [15:0]            verify_errors,
`endif
   edge_cache_loader_if.master    bus
);

   localparam int CW = NODE_BITS + 1;
   localparam int EW = 2 * NODE_BITS + 1;

   loader_state_t         r_state;
   logic [CW-1:0]         r_num;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_error;
   logic                  r_in_ready;
   logic                  r_write;
   logic [EW-1:0]         r_edges;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_data;

   logic [CW-1:0]         w_from;
   logic [CW-1:0]         w_to;
   logic                  w_last;
   logic                  w_n_ok;
   logic                  w_clear;
   logic                  w_advance;
   logic [ADDR_WIDTH-1:0] w_addr;

`ifdef EDGE_CACHE_LOADER_VERIFY_EN
   logic                  r_read;
   logic                  r_was_last;
   logic [15:0]           r_verr;
`else
   logic                  w_unused_rdata;
`endif

   assign w_n_ok = (cmd_num_nodes != '0) &&
                   (cmd_num_nodes <= CW'(1 << NODE_BITS));
   assign w_clear = (r_state == ST_IDLE) && cmd_start && w_n_ok;
   assign w_advance = (r_state == ST_WRITE) && !bus.m_waitrequest;
   assign w_addr = ADDR_WIDTH'(pack_edge_addr(32'(w_from),
                                              32'(w_to),
                                              NODE_BITS));

   edge_index_counter #(
      .NODE_BITS (NODE_BITS)
   ) u_idx (
      .clock       (clock),
      .reset       (reset),
      .i_clear     (w_clear),
      .i_advance   (w_advance),
      .i_num_nodes (r_num),
      .o_from      (w_from),
      .o_to        (w_to),
      .o_last      (w_last)
   );

   assign busy            = r_busy;
   assign done            = r_done;
   assign cmd_error       = r_error;
   assign edges_written   = r_edges;
   assign bus.in_ready    = r_in_ready;
   assign bus.m_write     = r_write;
   assign bus.m_address   = r_addr;
   assign bus.m_writedata = r_data;

`ifdef EDGE_CACHE_LOADER_VERIFY_EN
   assign bus.m_read      = r_read;
   assign verify_errors   = r_verr;
`else
   assign bus.m_read      = 1'b0;
   assign w_unused_rdata  = ^bus.m_readdata;
`endif

   // Load sequencer; every bus/status output is a register of this FSM.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_num      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_in_ready <= 1'b0;
         r_write    <= 1'b0;
         r_edges    <= '0;
         r_addr     <= '0;
         r_data     <= '0;
`ifdef EDGE_CACHE_LOADER_VERIFY_EN
         r_read     <= 1'b0;
         r_was_last <= 1'b0;
         r_verr     <= '0;
`endif
      end else begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (cmd_start) begin
                  if (w_n_ok) begin
                     r_num      <= cmd_num_nodes;
                     r_edges    <= '0;
                     r_busy     <= 1'b1;
                     r_in_ready <= 1'b1;
                     r_state    <= ST_FETCH;
`ifdef EDGE_CACHE_LOADER_VERIFY_EN
                     r_verr     <= '0;
`endif
                  end else begin
                     r_error <= 1'b1;
                  end
               end
            end
            ST_FETCH: begin
               if (bus.in_valid) begin
                  r_in_ready <= 1'b0;
                  r_data     <= bus.in_data;
                  r_addr     <= w_addr;
                  r_write    <= 1'b1;
                  r_state    <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (!bus.m_waitrequest) begin
                  r_write <= 1'b0;
                  r_edges <= r_edges + 1'b1;
`ifdef EDGE_CACHE_LOADER_VERIFY_EN
                  r_read     <= 1'b1;
                  r_was_last <= w_last;
                  r_state    <= ST_VERIFY;
`else
                  if (w_last) begin
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_in_ready <= 1'b1;
                     r_state    <= ST_FETCH;
                  end
`endif
               end
            end
`ifdef EDGE_CACHE_LOADER_VERIFY_EN
            ST_VERIFY: begin
               if (!bus.m_waitrequest) begin
                  r_read <= 1'b0;
                  if ((bus.m_readdata != r_data) &&
                      (r_verr != 16'hFFFF)) begin
                     r_verr <= r_verr + 16'd1;
                  end
                  if (r_was_last) begin
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_in_ready <= 1'b1;
                     r_state    <= ST_FETCH;
                  end
               end
            end
`endif
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_edge_cache_loader.sv
// tb_edge_cache_loader: randomized bench for edge_cache_loader.
// Honours EDGE_CACHE_LOADER_VERIFY_EN for the readback variant.
module tb_edge_cache_loader;

   localparam int NB = 7;
   localparam int AW = 16;
   localparam int DW = 32;
`ifdef EDGE_CACHE_LOADER_VERIFY_EN
   localparam int EC = 3;
`else
   localparam int EC = 2;
`endif

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            c;
   } wr_t;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic            cmd_start = 1'b0;
   logic [NB:0]     cmd_num_nodes = '0;
   logic            busy;
   logic            done;
   logic            cmd_error;
   logic [2*NB:0]   edges_written;
`ifdef EDGE_CACHE_LOADER_VERIFY_EN
   logic [15:0]     verify_errors;
`endif

   int checks = 0;
   int errors = 0;

   // owned by the test tasks
   logic [DW-1:0] exp_d[$];
   logic [DW-1:0] src_q[$];
   int  src_off = 0;
   int  wr_base = 0;
   int  d0 = 0;
   int  stall_n = 0;
   bit  rand_stall = 1'b0;
   bit  rand_valid = 1'b0;
   bit  corrupt_en = 1'b0;
   logic [AW-1:0] corrupt_a = '0;

   // owned by the bus model
   wr_t wr_q[$];
   logic [DW-1:0] mem [logic [AW-1:0]];
   int  cyc = 0;
   int  hs_total = 0;
   bit  hs_pend = 1'b0;
   int  wcnt = 0;
   bit  wt = 1'b0;
   bit  prev_stall = 1'b0;
   logic [AW-1:0] prev_a = '0;
   logic [DW-1:0] prev_d = '0;
   int  stab_bad = 0;
   int  act_cnt = 0;
   int  busy_cnt = 0;
   int  done_cnt = 0;
   int  err_cnt = 0;

   edge_cache_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   edge_cache_loader #(
      .NODE_BITS  (NB),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .cmd_start     (cmd_start),
      .cmd_num_nodes (cmd_num_nodes),
      .busy          (busy),
      .done          (done),
      .cmd_error     (cmd_error),
      .edges_written (edges_written),
`ifdef EDGE_CACHE_LOADER_VERIFY_EN
      .verify_errors (verify_errors),
`endif
      .bus           (bus)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // stream source, slave model and event counters, all on the falling edge
   always @(negedge clock) begin
      int idx;
      logic [DW-1:0] rd;
      if (hs_pend) begin
         hs_total = hs_total + 1;
         hs_pend = 1'b0;
      end
      idx = hs_total - src_off;
      if (idx >= 0 && idx < src_q.size() &&
          (!rand_valid || $urandom_range(0, 7) != 0)) begin
         bus.in_valid = 1'b1;
         bus.in_data = src_q[idx];
      end else begin
         bus.in_valid = 1'b0;
         bus.in_data = '0;
      end
      if (bus.in_valid && bus.in_ready) hs_pend = 1'b1;
      if (bus.m_write === 1'b1 || bus.m_read === 1'b1) begin
         if (rand_stall) begin
            wt = ($urandom_range(0, 3) == 0);
         end else begin
            wt = (wcnt < stall_n);
            wcnt = wt ? wcnt + 1 : 0;
         end
      end else begin
         wt = 1'b0;
         wcnt = 0;
      end
      bus.m_waitrequest = wt;
      rd = '0;
      if (bus.m_read === 1'b1) begin
         if (mem.exists(bus.m_address)) rd = mem[bus.m_address];
         if (corrupt_en && bus.m_address == corrupt_a) rd = rd ^ 32'h1;
      end
      bus.m_readdata = rd;
      if (bus.m_write === 1'b1 && prev_stall &&
          (bus.m_address !== prev_a || bus.m_writedata !== prev_d))
         stab_bad = stab_bad + 1;
      prev_stall = (bus.m_write === 1'b1) && wt;
      prev_a = bus.m_address;
      prev_d = bus.m_writedata;
      if (bus.m_write === 1'b1 && !wt) begin
         wr_q.push_back('{a: bus.m_address, d: bus.m_writedata, c: cyc});
         mem[bus.m_address] = bus.m_writedata;
      end
      if (bus.m_write === 1'b1 || bus.m_read === 1'b1 ||
          bus.in_ready === 1'b1) act_cnt = act_cnt + 1;
      if (busy === 1'b1) busy_cnt = busy_cnt + 1;
      if (done === 1'b1) done_cnt = done_cnt + 1;
      if (cmd_error === 1'b1) err_cnt = err_cnt + 1;
   end

   // row-major order: from = i / n, to = i % n; address {to, from}
   function automatic logic [AW-1:0] exp_addr(input int i, input int n);
      return AW'(((i % n) << NB) + (i / n));
   endfunction

   task automatic do_start(input int n);
      @(posedge clock); #1;
      cmd_start = 1'b1;
      cmd_num_nodes = (NB+1)'(n);
      @(posedge clock); #1;
      cmd_start = 1'b0;
   endtask

   task automatic start_load(input int n);
      src_q = exp_d;
      src_off = hs_total;
      wr_base = wr_q.size();
      d0 = done_cnt;
      do_start(n);
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && done_cnt == d0; i++) begin
         @(posedge clock); #1;
      end
      checks++;
      if (done_cnt == d0) begin
         errors++;
         $display("FAIL done_timeout: done pulses %0d, required %0d",
                  done_cnt - d0, 1);
      end
      repeat (2) @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL rst_busy: got %b, want 0", busy);
      end
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL rst_done: got %b, want 0", done);
      end
      checks++;
      if (cmd_error !== 1'b0) begin
         errors++; $display("FAIL rst_err: got %b, want 0", cmd_error);
      end
      checks++;
      if (edges_written !== '0) begin
         errors++; $display("FAIL rst_edges: got %0d, want 0", edges_written);
      end
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++; $display("FAIL rst_ready: got %b, want 0", bus.in_ready);
      end
      checks++;
      if (bus.m_write !== 1'b0 || bus.m_read !== 1'b0) begin
         errors++;
         $display("FAIL rst_wr_rd: got %b%b, want 00",
                  bus.m_write, bus.m_read);
      end
      checks++;
      if (bus.m_address !== '0 || bus.m_writedata !== '0) begin
         errors++;
         $display("FAIL rst_addr_data: got %h/%h, want 0/0",
                  bus.m_address, bus.m_writedata);
      end
`ifdef EDGE_CACHE_LOADER_VERIFY_EN
      checks++;
      if (verify_errors !== 16'd0) begin
         errors++; $display("FAIL rst_verr: got %0d, want 0", verify_errors);
      end
`endif
      reset = 1'b0;
   endtask

   task automatic test_basic();
      logic [AW-1:0] ea [4];
      ea = '{16'h0000, 16'h0080, 16'h0001, 16'h0081};
      exp_d = {32'd10, 32'd20, 32'd30, 32'd40};
      start_load(2);
      wait_done(200);
      checks++;
      if (wr_q.size() - wr_base != 4) begin
         errors++;
         $display("FAIL basic_count: got %0d, want 4", wr_q.size() - wr_base);
      end
      for (int i = 0; i < 4 && wr_base + i < wr_q.size(); i++) begin
         checks++;
         if (wr_q[wr_base+i].a !== ea[i] || wr_q[wr_base+i].d !== exp_d[i]) begin
            errors++;
            $display("FAIL basic_wr%0d: got %h/%0d, want %h/%0d", i,
                     wr_q[wr_base+i].a, wr_q[wr_base+i].d, ea[i], exp_d[i]);
         end
      end
      for (int i = 1; i < 4 && wr_base + i < wr_q.size(); i++) begin
         checks++;
         if (wr_q[wr_base+i].c - wr_q[wr_base+i-1].c != EC) begin
            errors++;
            $display("FAIL basic_rate%0d: got %0d cycles, want %0d", i,
                     wr_q[wr_base+i].c - wr_q[wr_base+i-1].c, EC);
         end
      end
      checks++;
      if (done_cnt - d0 != 1) begin
         errors++; $display("FAIL basic_done: got %0d, want 1", done_cnt - d0);
      end
      checks++;
      if (edges_written !== 15'd4 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_status: got edges %0d busy %b, want 4 0",
                  edges_written, busy);
      end
`ifdef EDGE_CACHE_LOADER_VERIFY_EN
      checks++;
      if (verify_errors !== 16'd0) begin
         errors++; $display("FAIL basic_verr: got %0d, want 0", verify_errors);
      end
`endif
   endtask

   task automatic test_stall();
      int e0;
      int s0;
      int bad;
      exp_d.delete();
      for (int i = 0; i < 9; i++) exp_d.push_back($urandom);
      stall_n = 3;
      e0 = err_cnt;
      s0 = stab_bad;
      start_load(3);
      repeat (4) @(posedge clock);
      do_start(0);
      wait_done(1000);
      stall_n = 0;
      checks++;
      if (wr_q.size() - wr_base != 9) begin
         errors++;
         $display("FAIL stall_count: got %0d, want 9", wr_q.size() - wr_base);
      end
      bad = 0;
      for (int i = 0; i < 9 && wr_base + i < wr_q.size(); i++) begin
         if (wr_q[wr_base+i].a !== exp_addr(i, 3) ||
             wr_q[wr_base+i].d !== exp_d[i]) bad++;
         if (i > 0 && wr_q[wr_base+i].c - wr_q[wr_base+i-1].c != EC + 3) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL stall_order: got %0d bad writes, want 0", bad);
      end
      checks++;
      if (stab_bad != s0) begin
         errors++;
         $display("FAIL stall_stable: got %0d changes, want 0", stab_bad - s0);
      end
      checks++;
      if (err_cnt != e0) begin
         errors++;
         $display("FAIL busy_start_err: got %0d pulses, want 0", err_cnt - e0);
      end
      checks++;
      if (edges_written !== 15'd9) begin
         errors++; $display("FAIL stall_edges: got %0d, want 9", edges_written);
      end
   endtask

   task automatic test_error();
      int nv [2];
      int a0;
      int b0;
      int e0;
      nv = '{0, 129};
      for (int k = 0; k < 2; k++) begin
         a0 = act_cnt;
         b0 = busy_cnt;
         e0 = err_cnt;
         do_start(nv[k]);
         checks++;
         if (cmd_error !== 1'b1) begin
            errors++;
            $display("FAIL err_pulse_n%0d: got %b, want 1", nv[k], cmd_error);
         end
         repeat (3) @(posedge clock);
         #1;
         checks++;
         if (err_cnt - e0 != 1) begin
            errors++;
            $display("FAIL err_width_n%0d: got %0d cycles, want 1",
                     nv[k], err_cnt - e0);
         end
         checks++;
         if (act_cnt != a0 || busy_cnt != b0) begin
            errors++;
            $display("FAIL err_quiet_n%0d: got act %0d busy %0d, want 0 0",
                     nv[k], act_cnt - a0, busy_cnt - b0);
         end
      end
   endtask

   task automatic test_reset_midload();
      bit seen;
      exp_d.delete();
      for (int i = 0; i < 9; i++) exp_d.push_back($urandom);
      stall_n = 1000;
      start_load(3);
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(posedge clock); #1;
         seen = (bus.m_write === 1'b1);
      end
      checks++;
      if (!seen) begin
         errors++; $display("FAIL mid_write_seen: got 0, want 1");
      end
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;
      checks++;
      if (bus.m_write !== 1'b0 || bus.in_ready !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst_ctl: got wr %b rdy %b busy %b, want 0 0 0",
                  bus.m_write, bus.in_ready, busy);
      end
      checks++;
      if (edges_written !== '0 || bus.m_address !== '0 ||
          bus.m_writedata !== '0) begin
         errors++;
         $display("FAIL mid_rst_regs: got %0d %h %h, want 0 0 0",
                  edges_written, bus.m_address, bus.m_writedata);
      end
      reset = 1'b0;
      stall_n = 0;
      exp_d = {32'($urandom)};
      start_load(1);
      wait_done(100);
      checks++;
      if (wr_q.size() - wr_base != 1 ||
          wr_q[wr_q.size()-1].a !== 16'h0000 ||
          wr_q[wr_q.size()-1].d !== exp_d[0]) begin
         errors++;
         $display("FAIL mid_n1_write: got %0d writes, last %h/%h, want 1 0/%h",
                  wr_q.size() - wr_base, wr_q[wr_q.size()-1].a,
                  wr_q[wr_q.size()-1].d, exp_d[0]);
      end
      checks++;
      if (edges_written !== 15'd1) begin
         errors++; $display("FAIL mid_n1_edges: got %0d, want 1", edges_written);
      end
   endtask

   task automatic test_random_stall();
      int bad;
      exp_d.delete();
      for (int i = 0; i < 25; i++) exp_d.push_back($urandom);
      rand_stall = 1'b1;
      rand_valid = 1'b1;
      start_load(5);
      wait_done(2000);
      rand_stall = 1'b0;
      rand_valid = 1'b0;
      bad = 0;
      for (int i = 0; i < 25 && wr_base + i < wr_q.size(); i++)
         if (wr_q[wr_base+i].a !== exp_addr(i, 5) ||
             wr_q[wr_base+i].d !== exp_d[i]) bad++;
      checks++;
      if (wr_q.size() - wr_base != 25 || bad != 0) begin
         errors++;
         $display("FAIL rstall_n5: got %0d writes %0d bad, want 25 0",
                  wr_q.size() - wr_base, bad);
      end
   endtask

   task automatic test_n128();
      int bad;
      exp_d.delete();
      for (int i = 0; i < 16384; i++) exp_d.push_back($urandom);
      rand_valid = 1'b1;
      start_load(128);
      wait_done(80000);
      rand_valid = 1'b0;
      checks++;
      if (wr_q.size() - wr_base != 16384) begin
         errors++;
         $display("FAIL n128_count: got %0d, want 16384", wr_q.size() - wr_base);
      end
      bad = 0;
      for (int i = 0; i < 16384 && wr_base + i < wr_q.size(); i++)
         if (wr_q[wr_base+i].a !== exp_addr(i, 128) ||
             wr_q[wr_base+i].d !== exp_d[i]) bad++;
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL n128_content: got %0d bad, want 0", bad);
      end
      checks++;
      if (wr_q[wr_q.size()-1].a !== 16'h3FFF) begin
         errors++;
         $display("FAIL n128_last: got %h, want 3fff", wr_q[wr_q.size()-1].a);
      end
      checks++;
      if (edges_written !== 15'd16384 || done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL n128_status: got edges %0d done %0d, want 16384 1",
                  edges_written, done_cnt - d0);
      end
   endtask

`ifdef EDGE_CACHE_LOADER_VERIFY_EN
   task automatic test_verify();
      exp_d.delete();
      for (int i = 0; i < 4; i++) exp_d.push_back($urandom);
      corrupt_en = 1'b1;
      corrupt_a = exp_addr(2, 2);
      start_load(2);
      wait_done(200);
      corrupt_en = 1'b0;
      checks++;
      if (verify_errors !== 16'd1) begin
         errors++; $display("FAIL verify_count: got %0d, want 1", verify_errors);
      end
      checks++;
      if (done_cnt - d0 != 1 || edges_written !== 15'd4) begin
         errors++;
         $display("FAIL verify_done: got done %0d edges %0d, want 1 4",
                  done_cnt - d0, edges_written);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_error();
      test_reset_midload();
      test_random_stall();
`ifdef EDGE_CACHE_LOADER_VERIFY_EN
      test_verify();
`endif
      test_n128();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
